logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-bit 2-input gates: WIDTH-bit bitwise logic unit with a selectable operation.
- Two-stage valid/ready pipeline. Stage 1 registers operands and opcode; stage 2 registers the result.
- Includes a wrapping count of delivered results.
- Sits between the nand2tetris gate library and the ALU datapath as a reusable, back-pressurable logic stage.

---
 rtl/logic_unit_pipe.sv | 153 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with a wrapping delivered-result counter.
// Optional reduction outputs (reduce_o) are built when LOGIC_UNIT_REDUCE_EN is defined.
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic [2:0]       op_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] Y_o,
  output logic             zero_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] count_o
`ifdef LOGIC_UNIT_REDUCE_EN
  ,
  output logic [1:0]       reduce_o
`endif
);

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = ~(a & b);
      3'b010:  r = a | b;
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      3'b111:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_s;
  logic             s2_free_s, s1_adv_s, in_xfer_s, out_xfer_s;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic [1:0]       red_q, red_d;
`endif

  // Handshake: stage 1 may advance whenever stage 2 is empty or draining.
  always_comb begin
    s2_free_s  = !s2_valid_q | ready_i;
    s1_adv_s   = s1_valid_q & s2_free_s;
    ready_o    = !rst_i & (!s1_valid_q | s2_free_s);
    in_xfer_s  = valid_i & ready_o;
    out_xfer_s = s2_valid_q & ready_i;
  end

  // Stage 1 next state: capture operands on an input transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (in_xfer_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = A_i;
      s1_b_d     = B_i;
      s1_op_d    = op_i;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: compute on advance, otherwise hold result stable.
  always_comb begin
    res_s      = apply_op(s1_op_q, s1_a_q, s1_b_q);
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    zero_d     = zero_q;
`ifdef LOGIC_UNIT_REDUCE_EN
    red_d      = red_q;
`endif
    if (s1_adv_s) begin
      s2_valid_d = 1'b1;
      y_d        = res_s;
      zero_d     = (res_s == '0);
`ifdef LOGIC_UNIT_REDUCE_EN
      red_d      = {parity_of(res_s), &res_s};
`endif
    end else if (out_xfer_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (out_xfer_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 3'b000;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b0;
      cnt_q      <= '0;
`ifdef LOGIC_UNIT_REDUCE_EN
      red_q      <= 2'b00;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      cnt_q      <= cnt_d;
`ifdef LOGIC_UNIT_REDUCE_EN
      red_q      <= red_d;
`endif
    end
  end

  assign Y_o     = y_q;
  assign zero_o  = zero_q;
  assign valid_o = s2_valid_q;
  assign count_o = cnt_q;
`ifdef LOGIC_UNIT_REDUCE_EN
  assign reduce_o = red_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4) with a result scoreboard.
module tb_logic_unit_pipe;

  logic       clk_i, rst_i, valid_i, ready_i;
  logic [7:0] A_i, B_i, Y_o;
  logic [2:0] op_i;
  logic       ready_o, zero_o, valid_o;
  logic [3:0] count_o;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic [1:0] reduce_o;
`endif

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .A_i(A_i), .B_i(B_i), .op_i(op_i),
    .valid_i(valid_i), .ready_o(ready_o), .Y_o(Y_o), .zero_o(zero_o),
    .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o)
`ifdef LOGIC_UNIT_REDUCE_EN
    , .reduce_o(reduce_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic [1:0] r;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] cnt_m = 4'd0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_y = 8'h00;
  logic [7:0] ops_tbl [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    valid_i = v; A_i = a; B_i = b; op_i = op;
    #1;
  endtask

  // One cycle: score transfers seen before the rising edge, then move to the next falling edge.
  task automatic tick();
    logic in_x, out_x;
    exp_t e, got;
    in_x  = valid_i & ready_o;
    out_x = valid_o & ready_i;
    chk("count", {28'd0, count_o}, {28'd0, cnt_m});
    if (hold_pend) begin
      chk("hold_y", {24'd0, Y_o}, {24'd0, hold_y});
      chk("hold_valid", {31'd0, valid_o}, 32'd1);
    end
    hold_pend = valid_o & !ready_i;
    hold_y    = Y_o;
    if (out_x) begin
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got.y = Y_o;
        got.z = zero_o;
`ifdef LOGIC_UNIT_REDUCE_EN
        got.r = reduce_o;
`else
        got.r = 2'b00;
`endif
        chk("sb_result", {21'd0, got}, {21'd0, e});
      end
      cnt_m = cnt_m + 4'd1;
    end
    if (in_x) begin
      e.y = model(op_i, A_i, B_i);
      e.z = (e.y == 8'h00);
`ifdef LOGIC_UNIT_REDUCE_EN
      e.r = {^e.y, &e.y};
`else
      e.r = 2'b00;
`endif
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; ready_i = 1'b1;
    valid_i = 1'b0; A_i = 8'h00; B_i = 8'h00; op_i = 3'd0;
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_y", {24'd0, Y_o}, 32'd0);
    chk("rst_zero", {31'd0, zero_o}, 32'd0);
    chk("rst_count", {28'd0, count_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    rst_i = 1'b0;
    #1 chk("rel_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);

    // All eight ops back to back: results on cycles 2..9, one per cycle.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 8'hF0, 8'hCC, 3'(i));
      else       drive(1'b0, 8'h00, 8'h00, 3'd0);
      if (i >= 2) begin
        chk("thru_valid", {31'd0, valid_o}, 32'd1);
        chk("ops_y", {24'd0, Y_o}, {24'd0, ops_tbl[i-2]});
      end
      tick();
    end

    drive(1'b1, 8'hAA, 8'h55, 3'd0); tick();
    drive(1'b1, 8'hAA, 8'h55, 3'd2); tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    chk("and_y", {24'd0, Y_o}, 32'h00);
    chk("and_zero", {31'd0, zero_o}, 32'd1);
    tick();
    chk("or_y", {24'd0, Y_o}, 32'hFF);
    chk("or_zero", {31'd0, zero_o}, 32'd0);
    tick(); tick();

    // Back-pressure: two beats fill the pipe, the third is held off.
    ready_i = 1'b0;
    drive(1'b1, 8'h01, 8'h01, 3'd0);
    chk("bp_ready1", {31'd0, ready_o}, 32'd1);
    tick();
    drive(1'b1, 8'h02, 8'h02, 3'd0);
    chk("bp_ready2", {31'd0, ready_o}, 32'd1);
    tick();
    drive(1'b1, 8'h03, 8'h03, 3'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_ready", {31'd0, ready_o}, 32'd0);
      chk("bp_y", {24'd0, Y_o}, 32'h01);
      tick();
    end
    ready_i = 1'b1; #1;
    chk("bp_take3", {31'd0, ready_o}, 32'd1);
    chk("drain_v0", {31'd0, valid_o}, 32'd1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    chk("drain_v1", {31'd0, valid_o}, 32'd1);
    chk("drain_y1", {24'd0, Y_o}, 32'h02);
    tick();
    chk("drain_v2", {31'd0, valid_o}, 32'd1);
    chk("drain_y2", {24'd0, Y_o}, 32'h03);
    tick();
    chk("drain_empty", {31'd0, valid_o}, 32'd0);

    // Reset in the middle of a stalled stream discards everything.
    ready_i = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 3'd2); tick();
    drive(1'b1, 8'h33, 8'h44, 3'd4); tick();
    #1 rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_y", {24'd0, Y_o}, 32'd0);
    chk("mid_rst_count", {28'd0, count_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    exp_q.delete(); cnt_m = 4'd0; hold_pend = 1'b0;
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("mid_rel_ready", {31'd0, ready_o}, 32'd1);
    tick();
    chk("post_rst_valid", {31'd0, valid_o}, 32'd0);

    // Counter wrap: 17 transfers end at 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 8'(8'hA5 ^ i), 3'(i));
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    tick(); tick(); tick();
    chk("wrap_count", {28'd0, count_o}, 32'd1);

`ifdef LOGIC_UNIT_REDUCE_EN
    drive(1'b1, 8'hFF, 8'hFF, 3'd0); tick();
    drive(1'b1, 8'h07, 8'h00, 3'd7); tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    chk("red_and", {30'd0, reduce_o}, 32'd1);
    tick();
    chk("red_par", {30'd0, reduce_o}, 32'd2);
    tick(); tick();
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
